// File: rtl/nav_pkg.sv
// Shared opcodes, FSM states and default turn speed for the navigation sequencer.
package nav_pkg;

    typedef enum logic [3:0] {
        OP_STOP   = 4'h0,
        OP_FOLLOW = 4'h1,
        OP_TURN_L = 4'h2,
        OP_TURN_R = 4'h3
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_TURN   = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    localparam logic signed [11:0] TURN_SPD_DEF = 12'sh180;

endpackage

// File: rtl/nav_turn_timer.sv
// Turn timer: free-running tick prescaler plus 12-bit tick down-counter.
// expire is combinational from state; it is only meaningful while a turn is active.
module nav_turn_timer #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] dur,
    output logic        expire
);

    localparam int PW = FAST_SIM ? 4 : 10;

    logic [PW-1:0] pre;
    logic [11:0]   cnt;
    logic          first;
    logic          tick;

    assign tick   = &pre;
    // A zero duration must finish on the very first turn cycle, not wait for a tick.
    assign expire = (cnt == 12'd0) && (tick || first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            cnt   <= 12'd0;
            first <= 1'b0;
        end else if (load) begin
            pre   <= '0;
            cnt   <= dur;
            first <= 1'b1;
        end else begin
            pre   <= pre + {{(PW-1){1'b0}}, 1'b1};
            first <= 1'b0;
            if (tick && (cnt != 12'd0))
                cnt <= cnt - 12'd1;
        end
    end

endmodule

// File: rtl/nav_ctrl.sv
// Mission sequencer: decodes commands, gates PID go, runs timed spin turns
// and latches a line-lost alarm. All outputs registered from next-state.
module nav_ctrl
    import nav_pkg::*;
#(
    parameter bit               FAST_SIM     = 1'b0,
    parameter logic signed [11:0] TURN_SPD   = TURN_SPD_DEF,
    parameter int               LOST_SAMPLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        cmd,
    input  logic               cmd_rdy,
    output logic               clr_cmd_rdy,
    input  logic               err_vld,
    input  logic               line_present,
    output logic               go,
    output logic               turn_en,
    output logic signed [11:0] lft_ovr,
    output logic signed [11:0] rght_ovr,
    output logic               buzz,
    output logic               done,
    output logic               cmd_err
);

    localparam int LW = $clog2(LOST_SAMPLES + 1);
    localparam logic [LW-1:0] LOST_MAX = LW'(LOST_SAMPLES);

    state_t        state, state_nxt;
    logic          left, left_nxt;
    logic [LW-1:0] lost_cnt, lost_nxt, lost_inc;
    logic [3:0]    op;
    logic          accept, is_turn, expire, tmr_load, done_nxt, err_nxt;

    // clr_cmd_rdy high means upstream is still dropping cmd_rdy; don't re-accept.
    assign accept   = cmd_rdy & ~clr_cmd_rdy;
    assign op       = cmd[15:12];
    assign is_turn  = (op == OP_TURN_L) || (op == OP_TURN_R);
    assign lost_inc = (lost_cnt == LOST_MAX) ? lost_cnt : lost_cnt + {{(LW-1){1'b0}}, 1'b1};

    nav_turn_timer #(.FAST_SIM(FAST_SIM)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .dur    (cmd[11:0]),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        left_nxt  = left;
        lost_nxt  = lost_cnt;
        tmr_load  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                lost_nxt = '0;
                if (accept) begin
                    if (op == OP_FOLLOW) begin
                        state_nxt = ST_FOLLOW;
                    end else if (is_turn) begin
                        state_nxt = ST_TURN;
                        tmr_load  = 1'b1;
                        left_nxt  = (op == OP_TURN_L);
                    end else if (op != OP_STOP) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_FOLLOW: begin
                if (err_vld)
                    lost_nxt = line_present ? '0 : lost_inc;
                // A command accepted this cycle takes priority over declaring loss.
                if (accept) begin
                    if (op == OP_STOP) begin
                        state_nxt = ST_IDLE;
                    end else if (is_turn) begin
                        state_nxt = ST_TURN;
                        tmr_load  = 1'b1;
                        left_nxt  = (op == OP_TURN_L);
                    end else if (op != OP_FOLLOW) begin
                        err_nxt = 1'b1;
                    end
                end else if (lost_nxt == LOST_MAX) begin
                    state_nxt = ST_LOST;
                end
            end
            ST_TURN: begin
                lost_nxt = '0;
                if (accept && (op == OP_STOP)) begin
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ST_LOST: begin
                if (accept && (op == OP_STOP)) begin
                    state_nxt = ST_IDLE;
                    lost_nxt  = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            left        <= 1'b0;
            lost_cnt    <= '0;
            go          <= 1'b0;
            turn_en     <= 1'b0;
            lft_ovr     <= 12'sd0;
            rght_ovr    <= 12'sd0;
            buzz        <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            left        <= left_nxt;
            lost_cnt    <= lost_nxt;
            go          <= (state_nxt == ST_FOLLOW);
            turn_en     <= (state_nxt == ST_TURN);
            buzz        <= (state_nxt == ST_LOST);
            clr_cmd_rdy <= accept;
            done        <= done_nxt;
            cmd_err     <= err_nxt;
            if (state_nxt == ST_TURN) begin
                lft_ovr  <= left_nxt ? -TURN_SPD : TURN_SPD;
                rght_ovr <= left_nxt ? TURN_SPD : -TURN_SPD;
            end else begin
                lft_ovr  <= 12'sd0;
                rght_ovr <= 12'sd0;
            end
        end
    end

endmodule

// File: tb/tb_nav_ctrl.sv
// Directed bench for nav_ctrl: command handshake, line-loss alarm, timed turns, abort, async reset.
module tb_nav_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [15:0]        cmd = 16'h0000;
    logic               cmd_rdy = 1'b0;
    logic               err_vld = 1'b0;
    logic               line_present = 1'b0;
    logic               clr_cmd_rdy, go, turn_en, buzz, done, cmd_err;
    logic signed [11:0] lft_ovr, rght_ovr;

    int nvec = 0;
    int nerr = 0;

    nav_ctrl #(.FAST_SIM(1'b1), .TURN_SPD(12'sh180), .LOST_SAMPLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .err_vld      (err_vld),
        .line_present (line_present),
        .go           (go),
        .turn_en      (turn_en),
        .lft_ovr      (lft_ovr),
        .rght_ovr     (rght_ovr),
        .buzz         (buzz),
        .done         (done),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        int n;
        cmd     = c;
        cmd_rdy = 1'b1;
        n       = 0;
        do begin
            step();
            n++;
        end while (clr_cmd_rdy !== 1'b1 && n < 4);
        cmd_rdy = 1'b0;
        nvec++;
        if (clr_cmd_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL send_cmd_%h: clr_cmd_rdy=%b after %0d cycles, required 1", c, clr_cmd_rdy, n);
        end
    endtask

    task automatic pulse_err(input logic lp);
        err_vld      = 1'b1;
        line_present = lp;
        step();
        err_vld      = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        nvec++;
        if ({go, turn_en, lft_ovr, rght_ovr, buzz, clr_cmd_rdy, done, cmd_err} !== 31'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got go=%b turn_en=%b lft=%0d rght=%0d buzz=%b clr=%b done=%b err=%b, required all 0",
                     go, turn_en, lft_ovr, rght_ovr, buzz, clr_cmd_rdy, done, cmd_err);
        end
        rst_n = 1'b1;
        step();
        nvec++;
        if (go !== 1'b0 || turn_en !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle: go=%b turn_en=%b, required 0 0", go, turn_en);
        end
    endtask

    task automatic test_follow_handshake();
        cmd     = 16'h1000;
        cmd_rdy = 1'b1;
        step();
        nvec++;
        if (clr_cmd_rdy !== 1'b1 || go !== 1'b1) begin
            nerr++;
            $display("FAIL follow_accept: clr=%b go=%b, required 1 1", clr_cmd_rdy, go);
        end
        step();
        nvec++;
        if (clr_cmd_rdy !== 1'b0) begin
            nerr++;
            $display("FAIL no_double_accept: clr=%b, required 0", clr_cmd_rdy);
        end
        cmd_rdy = 1'b0;
        step();
        nvec++;
        if (clr_cmd_rdy !== 1'b0 || go !== 1'b1) begin
            nerr++;
            $display("FAIL follow_hold: clr=%b go=%b, required 0 1", clr_cmd_rdy, go);
        end
    endtask

    task automatic test_line_lost();
        for (int i = 0; i < 7; i++) pulse_err(1'b0);
        pulse_err(1'b1);
        for (int i = 0; i < 7; i++) pulse_err(1'b0);
        nvec++;
        if (go !== 1'b1 || buzz !== 1'b0) begin
            nerr++;
            $display("FAIL lost_7_1_7: go=%b buzz=%b, required 1 0", go, buzz);
        end
        pulse_err(1'b1);
        for (int i = 0; i < 7; i++) pulse_err(1'b0);
        nvec++;
        if (go !== 1'b1 || buzz !== 1'b0) begin
            nerr++;
            $display("FAIL lost_after_7: go=%b buzz=%b, required 1 0", go, buzz);
        end
        pulse_err(1'b0);
        nvec++;
        if (go !== 1'b0 || buzz !== 1'b1) begin
            nerr++;
            $display("FAIL lost_after_8: go=%b buzz=%b, required 0 1", go, buzz);
        end
        send_cmd(16'h2005);
        nvec++;
        if (buzz !== 1'b1 || turn_en !== 1'b0) begin
            nerr++;
            $display("FAIL lost_ignores_turn: buzz=%b turn_en=%b, required 1 0", buzz, turn_en);
        end
        send_cmd(16'h0000);
        nvec++;
        if (buzz !== 1'b0 || go !== 1'b0) begin
            nerr++;
            $display("FAIL lost_stop: buzz=%b go=%b, required 0 0", buzz, go);
        end
        step();
    endtask

    task automatic test_turn_left();
        int n;
        int drop;
        send_cmd(16'h2003);
        nvec++;
        if (turn_en !== 1'b1 || lft_ovr !== -12'sd384 || rght_ovr !== 12'sd384) begin
            nerr++;
            $display("FAIL turn_l_ovr: turn_en=%b lft=%0d rght=%0d, required 1 -384 384", turn_en, lft_ovr, rght_ovr);
        end
        n    = 0;
        drop = 0;
        while (done !== 1'b1 && n < 200) begin
            if (turn_en !== 1'b1) drop++;
            step();
            n++;
        end
        nvec++;
        if (n < 48 || n > 80 || drop != 0) begin
            nerr++;
            $display("FAIL turn_l_time: done after %0d cycles with %0d turn_en drops, required 48..80 and 0", n, drop);
        end
        nvec++;
        if (turn_en !== 1'b0 || lft_ovr !== 12'sd0 || rght_ovr !== 12'sd0) begin
            nerr++;
            $display("FAIL turn_l_exit: turn_en=%b lft=%0d rght=%0d, required 0 0 0", turn_en, lft_ovr, rght_ovr);
        end
        step();
        nvec++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL turn_l_done_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            send_cmd(16'h3000);
            nvec++;
            if (turn_en !== 1'b1 || rght_ovr !== -12'sd384 || lft_ovr !== 12'sd384 || done !== 1'b0) begin
                nerr++;
                $display("FAIL turn_r0_%0d_enter: turn_en=%b lft=%0d rght=%0d done=%b, required 1 384 -384 0",
                         k, turn_en, lft_ovr, rght_ovr, done);
            end
            step();
            nvec++;
            if (done !== 1'b1 || turn_en !== 1'b0 || rght_ovr !== 12'sd0) begin
                nerr++;
                $display("FAIL turn_r0_%0d_done: done=%b turn_en=%b rght=%0d, required 1 0 0", k, done, turn_en, rght_ovr);
            end
        end
        step();
    endtask

    task automatic test_abort_illegal();
        int pulses;
        send_cmd(16'h2005);
        for (int i = 0; i < 10; i++) step();
        send_cmd(16'h0000);
        nvec++;
        if (turn_en !== 1'b0 || lft_ovr !== 12'sd0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL abort: turn_en=%b lft=%0d done=%b, required 0 0 0", turn_en, lft_ovr, done);
        end
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        nvec++;
        if (pulses != 0) begin
            nerr++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", pulses);
        end
        send_cmd(16'h7000);
        nvec++;
        if (cmd_err !== 1'b1 || go !== 1'b0 || turn_en !== 1'b0) begin
            nerr++;
            $display("FAIL illegal_idle: cmd_err=%b go=%b turn_en=%b, required 1 0 0", cmd_err, go, turn_en);
        end
        step();
        nvec++;
        if (cmd_err !== 1'b0 || clr_cmd_rdy !== 1'b0) begin
            nerr++;
            $display("FAIL illegal_pulse: cmd_err=%b clr=%b, required 0 0", cmd_err, clr_cmd_rdy);
        end
        send_cmd(16'h1000);
        send_cmd(16'hF123);
        nvec++;
        if (cmd_err !== 1'b1 || go !== 1'b1) begin
            nerr++;
            $display("FAIL illegal_follow: cmd_err=%b go=%b, required 1 1", cmd_err, go);
        end
        step();
        send_cmd(16'h3000);
        nvec++;
        if (go !== 1'b0 || turn_en !== 1'b1) begin
            nerr++;
            $display("FAIL follow_to_turn: go=%b turn_en=%b, required 0 1", go, turn_en);
        end
        step();
        nvec++;
        if (done !== 1'b1 || go !== 1'b0) begin
            nerr++;
            $display("FAIL follow_turn_done: done=%b go=%b, required 1 0", done, go);
        end
        step();
    endtask

    task automatic test_async_reset();
        send_cmd(16'h3005);
        for (int i = 0; i < 5; i++) step();
        nvec++;
        if (turn_en !== 1'b1) begin
            nerr++;
            $display("FAIL async_pre: turn_en=%b, required 1", turn_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({go, turn_en, lft_ovr, rght_ovr, buzz, clr_cmd_rdy, done, cmd_err} !== 31'd0) begin
            nerr++;
            $display("FAIL async_reset: turn_en=%b lft=%0d rght=%0d, required all outputs 0", turn_en, lft_ovr, rght_ovr);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        nvec++;
        if (turn_en !== 1'b0 || go !== 1'b0) begin
            nerr++;
            $display("FAIL async_post: turn_en=%b go=%b, required 0 0", turn_en, go);
        end
    endtask

    initial begin
        test_reset();
        test_follow_handshake();
        test_line_lost();
        test_turn_left();
        test_back_to_back();
        test_abort_illegal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nav_ctrl.md
Name: nav_ctrl

Overview:
- Mission sequencer for the line-following robot. It decodes commands from the command receiver and gates the PID `go` signal.
- Runs timed open-loop spin turns by driving override wheel speeds. The motor mux selects these speeds while `turn_en` is high.
- Detects sustained line loss from the PID error stream, halts the robot and raises an alarm.

Parameters:
FAST_SIM, 0, 1 shrinks the turn-tick prescaler from 2^10 clocks to 2^4 clocks for simulation.
TURN_SPD, 12'h180, magnitude of the override wheel speed during a spin turn.
LOST_SAMPLES, 8, number of consecutive err_vld samples with line_present low that declares the line lost.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cmd  in  16  command word; [15:12] opcode, [11:0] turn duration in ticks
cmd_rdy  in  1  cmd valid; held high until clr_cmd_rdy is seen
clr_cmd_rdy  out  1  one-cycle pulse: cmd consumed
err_vld  in  1  PID error sample strobe
line_present  in  1  sensor sees the line; qualified by err_vld
go  out  1  enable to PID / forward ramp
turn_en  out  1  motor mux selects override speeds
lft_ovr  out  12 signed  left override speed
rght_ovr  out  12 signed  right override speed
buzz  out  1  line-lost alarm
done  out  1  one-cycle pulse when a turn completes
cmd_err  out  1  one-cycle pulse when an illegal opcode is received

Behaviour:
- Every output is registered. Reset values: go=0, turn_en=0, lft_ovr=0, rght_ovr=0, buzz=0, clr_cmd_rdy=0, done=0, cmd_err=0. State resets to IDLE, timer to 0, lost counter to 0.
- Opcodes: 4'h0 STOP, 4'h1 FOLLOW, 4'h2 TURN_L, 4'h3 TURN_R. All other opcodes are illegal.
- Command acceptance: a command is accepted at a rising edge when cmd_rdy=1 and clr_cmd_rdy=0. This rule blocks a double-accept while upstream is clearing cmd_rdy.
  - Acceptance raises clr_cmd_rdy for exactly one cycle, whether the command is acted on or ignored.
  - Outputs reflect the new state one cycle after acceptance.
- IDLE: go=0, turn_en=0.
  - FOLLOW goes to FOLLOW with go=1 and the lost counter cleared.
  - TURN_L/TURN_R load the timer with cmd[11:0] and go to TURN.
  - STOP stays in IDLE.
  - An illegal opcode pulses cmd_err and stays in IDLE.
- FOLLOW: go=1.
  - STOP goes to IDLE.
  - TURN_x sets go=0 and goes to TURN; the same cycle loads the timer.
  - FOLLOW is ignored. An illegal opcode pulses cmd_err.
  - Lost counter: on each err_vld with line_present=0 it increments (saturating). On err_vld with line_present=1 it clears. With err_vld=0 it holds.
  - When the counter reaches LOST_SAMPLES, go to LOST.
  - If a command is accepted in the same cycle the counter would reach LOST_SAMPLES, the command wins.
- TURN: turn_en=1, go=0.
  - TURN_L: lft_ovr=-TURN_SPD, rght_ovr=+TURN_SPD. TURN_R: the signs are mirrored.
  - A tick prescaler free-runs from TURN entry. Each tick decrements the timer.
  - When the timer is 0 at a tick, or 0 on entry, go to IDLE and pulse done. Duration 0 therefore completes on the first cycle in TURN.
  - On TURN exit: turn_en=0, lft_ovr=0, rght_ovr=0.
  - STOP aborts to IDLE without a done pulse. All other commands are consumed and ignored.
- LOST: go=0, buzz=1.
  - Only STOP exits, to IDLE with buzz=0 and the counter cleared. Other commands are consumed and ignored.
- A reset assertion mid-turn or mid-follow forces the reset values immediately (asynchronous reset).
- Prescaler width: 10 bits, or 4 bits when FAST_SIM=1. It clears on TURN entry.

Decomposition:
- nav_pkg holds:
  - opcode enum: STOP, FOLLOW, TURN_L, TURN_R
  - state enum: IDLE, FOLLOW, TURN, LOST
  - TURN_SPD default constant
- One sub-module, nav_turn_timer: prescaler plus 12-bit down-counter.
  - Inputs: load, dur, FAST_SIM parameter.
  - Output: expire pulse.
- The FSM, lost counter and output registers stay in nav_ctrl.

Test Plan:
1. Reset, then cmd=16'h1000 with cmd_rdy. Required: one clr_cmd_rdy pulse; go=1 one cycle after acceptance; holding cmd_rdy through the clear cycle does not cause a second accept.
2. In FOLLOW, drive 8 err_vld pulses with line_present=0, separated by idle cycles. Required: go=0 and buzz=1 after the 8th. A 7-low/1-high/7-low pattern must never trip. Then cmd=16'h0000 clears buzz and returns to IDLE.
3. FAST_SIM=1, cmd=16'h2003. Required: turn_en=1, lft_ovr=-384, rght_ovr=+384; done pulses after 4 ticks (~64 clocks, ±1 tick); then all overrides are 0.
4. cmd=16'h3000. Required: immediate single-cycle TURN with rght_ovr=-384, then done; a second identical command repeats the same behaviour.
5. During a TURN, send STOP. Required: abort to IDLE, turn_en=0, no done pulse. Send cmd=16'h7000 in IDLE. Required: cmd_err pulse, clr_cmd_rdy pulse, state unchanged.
6. Assert rst_n low mid-TURN, asynchronously between clock edges. Required: all outputs are 0 before the next edge.
